// File: rtl/pc_unit.sv
// Program counter with boot cycle, stall-time request latching and
// trap/redirect priority; misaligned redirect targets are converted to traps.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     INC          = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    output logic [XLEN-1:0] port_out,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            pc_valid,
    output logic            pending,
    output logic            misaligned
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ptrap_q, ptrap_d;
    logic            predir_q, predir_d;
    logic [XLEN-1:0] ptgt_q, ptgt_d;
    logic            mis_q, mis_d;

    logic active;
    logic tgt_unaligned;
    logic in_trap;
    logic in_redir;

    assign port_out    = pc_q;
    assign pc_plus_inc = pc_q + XLEN'(INC);
    assign pc_valid    = (state_q != BOOT);
    assign pending     = (state_q == PEND);
    assign misaligned  = mis_q;

    // Requests only count outside BOOT; an unaligned redirect becomes a trap
    // unless a real trap arrives in the same cycle, which discards it silently.
    assign active        = (state_q != BOOT);
    assign tgt_unaligned = (redirect_target[1:0] != 2'b00);
    assign in_trap       = active & (trap_valid | (redirect_valid & tgt_unaligned));
    assign in_redir      = active & redirect_valid & ~trap_valid & ~tgt_unaligned;

    always_comb begin
        pc_d     = pc_q;
        ptrap_d  = ptrap_q;
        predir_d = predir_q;
        ptgt_d   = ptgt_q;
        mis_d    = active & redirect_valid & ~trap_valid & tgt_unaligned;
        state_d  = RUN;

        if (enable) begin
            if (in_trap || ptrap_q) begin
                pc_d = TRAP_VECTOR;
            end else if (in_redir) begin
                pc_d = redirect_target;
            end else if (predir_q) begin
                pc_d = ptgt_q;
            end else begin
                pc_d = pc_plus_inc;
            end
            ptrap_d  = 1'b0;
            predir_d = 1'b0;
        end else begin
            if (in_trap) begin
                ptrap_d  = 1'b1;
                predir_d = 1'b0;
            end else if (in_redir && !ptrap_q) begin
                predir_d = 1'b1;
                ptgt_d   = redirect_target;
            end
            state_d = (ptrap_d || predir_d) ? PEND : RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            ptrap_q  <= 1'b0;
            predir_q <= 1'b0;
            ptgt_q   <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ptrap_q  <= ptrap_d;
            predir_q <= predir_d;
            ptgt_q   <= ptgt_d;
            mis_q    <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a request-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] port_out;
    logic [31:0] pc_plus_inc;
    logic        pc_valid;
    logic        pending;
    logic        misaligned;

    pc_unit #(
        .XLEN        (32),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR (TV),
        .INC         (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid     (trap_valid),
        .port_out       (port_out),
        .pc_plus_inc    (pc_plus_inc),
        .pc_valid       (pc_valid),
        .pending        (pending),
        .misaligned     (misaligned)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Reference model: kind of held request is 0 none, 1 redirect, 2 trap.
    bit          m_boot;
    logic [31:0] m_pc;
    int          m_kind;
    logic [31:0] m_tgt;
    bit          m_mis;

    always @(posedge clock) begin
        int req;
        if (reset) begin
            m_boot = 1'b1;
            m_pc   = RV;
            m_kind = 0;
            m_mis  = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_mis  = 1'b0;
            if (enable) m_pc = m_pc + 32'd4;
        end else begin
            if (trap_valid) req = 2;
            else if (redirect_valid) req = (redirect_target % 4 != 0) ? 2 : 1;
            else req = 0;
            m_mis = redirect_valid && !trap_valid && (redirect_target % 4 != 0);
            if (enable) begin
                if (req == 2 || m_kind == 2) m_pc = TV;
                else if (req == 1)           m_pc = redirect_target;
                else if (m_kind == 1)        m_pc = m_tgt;
                else                         m_pc = m_pc + 32'd4;
                m_kind = 0;
            end else if (req == 2) begin
                m_kind = 2;
            end else if (req == 1 && m_kind != 2) begin
                m_kind = 1;
                m_tgt  = redirect_target;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            cmp("model port_out",    port_out,            m_pc);
            cmp("model pc_plus_inc", pc_plus_inc,         m_pc + 32'd4);
            cmp("model pc_valid",    {31'b0, pc_valid},   {31'b0, !m_boot});
            cmp("model pending",     {31'b0, pending},    {31'b0, m_kind != 0});
            cmp("model misaligned",  {31'b0, misaligned}, {31'b0, m_mis});
        end
    end

    task automatic step(input logic rst, input logic en, input logic rv,
                        input logic [31:0] rt, input logic tv);
        reset           = rst;
        enable          = en;
        redirect_valid  = rv;
        redirect_target = rt;
        trap_valid      = tv;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; redirect_valid = 1'b0;
        redirect_target = '0; trap_valid = 1'b0;

        // Reset then sequential advance
        step(1, 1, 0, 0, 0);
        check_en = 1'b1;
        cmp("reset port_out", port_out, 32'h0);
        cmp("reset pc_valid", {31'b0, pc_valid}, 32'd0);
        cmp("reset pending",  {31'b0, pending}, 32'd0);
        step(0, 1, 0, 0, 0);
        cmp("first advance", port_out, 32'h4);
        cmp("valid after boot", {31'b0, pc_valid}, 32'd1);
        step(0, 1, 0, 0, 0); cmp("seq 8", port_out, 32'h8);
        step(0, 1, 0, 0, 0); cmp("seq C", port_out, 32'hC);
        step(0, 1, 0, 0, 0); cmp("seq 10", port_out, 32'h10);

        // Stall with latched redirect
        step(0, 0, 1, 32'h200, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cmp("stall holds", port_out, 32'h10);
        cmp("stall pending", {31'b0, pending}, 32'd1);
        step(0, 1, 0, 0, 0);
        cmp("release redirect", port_out, 32'h200);
        cmp("release pending clr", {31'b0, pending}, 32'd0);

        // Redirect, trap, redirect while stalled: trap survives
        step(0, 0, 1, 32'h300, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h400, 0);
        step(0, 1, 0, 0, 0);
        cmp("pending trap wins", port_out, 32'h100);

        // Misaligned redirect
        step(0, 1, 1, 32'h202, 0);
        cmp("misaligned to trap", port_out, 32'h100);
        cmp("misaligned pulse", {31'b0, misaligned}, 32'd1);
        step(0, 1, 0, 0, 0);
        cmp("misaligned one cycle", {31'b0, misaligned}, 32'd0);
        cmp("after trap seq", port_out, 32'h104);

        // Trap and redirect together
        step(0, 1, 1, 32'h500, 1);
        cmp("trap beats redirect", port_out, 32'h100);
        cmp("no misaligned", {31'b0, misaligned}, 32'd0);
        step(0, 1, 1, 32'h502, 1);
        cmp("trap beats bad redirect mis", {31'b0, misaligned}, 32'd0);

        // Pending trap beats incoming redirect; incoming redirect beats pending redirect
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 32'h600, 0);
        cmp("pending trap > redirect", port_out, 32'h100);
        step(0, 0, 1, 32'h700, 0);
        step(0, 1, 1, 32'h800, 0);
        cmp("incoming > pending redirect", port_out, 32'h800);
        step(0, 0, 1, 32'h900, 0);
        step(0, 0, 1, 32'hA00, 0);
        step(0, 1, 0, 0, 0);
        cmp("redirect overwrite", port_out, 32'hA00);

        // Misaligned redirect while stalled
        step(0, 0, 1, 32'h701, 0);
        cmp("stalled misaligned pulse", {31'b0, misaligned}, 32'd1);
        step(0, 1, 0, 0, 0);
        cmp("stalled misaligned trap", port_out, 32'h100);

        // Wrap
        step(0, 1, 1, 32'hFFFF_FFFC, 0);
        cmp("load top", port_out, 32'hFFFF_FFFC);
        cmp("plus_inc wraps", pc_plus_inc, 32'h0);
        step(0, 1, 0, 0, 0);
        cmp("wrap to zero", port_out, 32'h0);

        // Reset during PEND, requests in BOOT ignored
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 32'h40, 0);
        cmp("pend before reset", {31'b0, pending}, 32'd1);
        step(1, 0, 0, 0, 0);
        cmp("reset clears pending", {31'b0, pending}, 32'd0);
        cmp("reset pc", port_out, 32'h0);
        cmp("reset valid", {31'b0, pc_valid}, 32'd0);
        step(0, 1, 1, 32'h80, 1);
        cmp("boot ignores requests", port_out, 32'h4);
        cmp("boot no misaligned", {31'b0, misaligned}, 32'd0);
        step(0, 1, 0, 0, 0);
        cmp("no stale pending", port_out, 32'h8);

        // Boot with stall, then resume
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cmp("boot stall holds", port_out, 32'h0);
        cmp("boot stall valid", {31'b0, pc_valid}, 32'd1);
        step(0, 1, 0, 0, 0);
        cmp("resume from reset vec", port_out, 32'h4);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
